// File: rtl/muldiv_sequencer_if.sv
// Handshake and data bundle between a pipeline stage and the iterative
// multiply/divide sequencer.
interface muldiv_sequencer_if;
    logic        START;
    logic [2:0]  FUNC3;
    logic [31:0] OPERAND1;
    logic [31:0] OPERAND2;
    logic        FLUSH;
    logic        BUSY;
    logic        STALL;
    logic        DONE;
    logic [31:0] RESULT;

    modport master (
        output START, FUNC3, OPERAND1, OPERAND2, FLUSH,
        input  BUSY, STALL, DONE, RESULT
    );

    modport slave (
        input  START, FUNC3, OPERAND1, OPERAND2, FLUSH,
        output BUSY, STALL, DONE, RESULT
    );
endinterface

// File: rtl/muldiv_sequencer.sv
// Iterative RV32M multiply/divide sequencer: one shift-add or restoring-divide
// step per clock on operand magnitudes, sign fixed up when RESULT is loaded.
//
// state  | meaning
// IDLE   | waiting for START
// MUL    | 32 shift-add iterations in progress
// DIV    | 32 restoring-divide iterations in progress
// DONE   | RESULT valid for one cycle; START here chains the next operation
module muldiv_sequencer (
    input  logic                CLK,
    input  logic                RESET,
    muldiv_sequencer_if.slave   bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t      state_q;
    logic [4:0]  cnt_q;
    logic [1:0]  func3_q;
    logic        neg_q;
    logic [31:0] opb_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic [31:0] result_q;
    logic        busy_q;
    logic        done_q;

    logic        accept;
    logic        op1_signed;
    logic        op2_signed;
    logic        neg1;
    logic        neg2;
    logic        start_neg_d;
    logic [31:0] mag_a_d;
    logic [31:0] mag_b_d;
    logic        div_zero;
    logic        div_ovf;
    logic [31:0] special_result_d;

    logic [32:0] mul_sum;
    logic [31:0] mul_hi_d;
    logic [31:0] mul_lo_d;
    logic [63:0] mul_prod;
    logic [63:0] mul_signed;
    logic [31:0] mul_result_d;

    logic [32:0] div_shift;
    logic [32:0] div_diff;
    logic        div_ge;
    logic [31:0] div_hi_d;
    logic [31:0] div_lo_d;
    logic [31:0] div_result_d;

    assign accept = (state_q == S_IDLE) || (state_q == S_DONE);

    // Operand decode at the START edge: which operands carry a sign.
    always_comb begin
        op1_signed = 1'b0;
        op2_signed = 1'b0;
        case (bus.FUNC3)
            3'b001: begin op1_signed = 1'b1; op2_signed = 1'b1; end
            3'b010: begin op1_signed = 1'b1; op2_signed = 1'b0; end
            3'b100: begin op1_signed = 1'b1; op2_signed = 1'b1; end
            3'b110: begin op1_signed = 1'b1; op2_signed = 1'b1; end
            default: begin op1_signed = 1'b0; op2_signed = 1'b0; end
        endcase
    end

    assign neg1    = op1_signed & bus.OPERAND1[31];
    assign neg2    = op2_signed & bus.OPERAND2[31];
    assign mag_a_d = neg1 ? (32'd0 - bus.OPERAND1) : bus.OPERAND1;
    assign mag_b_d = neg2 ? (32'd0 - bus.OPERAND2) : bus.OPERAND2;

    // Remainder takes the dividend's sign; everything else the sign product.
    assign start_neg_d = (bus.FUNC3 == 3'b110) ? neg1 : (neg1 ^ neg2);

    assign div_zero = bus.FUNC3[2] && (bus.OPERAND2 == 32'd0);
    assign div_ovf  = (bus.FUNC3 == 3'b100 || bus.FUNC3 == 3'b110) &&
                      (bus.OPERAND1 == 32'h8000_0000) &&
                      (bus.OPERAND2 == 32'hFFFF_FFFF);

    always_comb begin
        special_result_d = 32'd0;
        if (div_zero) begin
            special_result_d = bus.FUNC3[1] ? bus.OPERAND1 : 32'hFFFF_FFFF;
        end else if (div_ovf) begin
            special_result_d = bus.FUNC3[1] ? 32'd0 : 32'h8000_0000;
        end
    end

    // Shift-add step: {hi,lo} holds partial product over remaining multiplier bits.
    assign mul_sum    = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : 33'd0);
    assign mul_hi_d   = mul_sum[32:1];
    assign mul_lo_d   = {mul_sum[0], lo_q[31:1]};
    assign mul_prod   = {mul_hi_d, mul_lo_d};
    assign mul_signed = neg_q ? (64'd0 - mul_prod) : mul_prod;
    assign mul_result_d = (func3_q == 2'b00) ? mul_signed[31:0] : mul_signed[63:32];

    // Restoring step: hi is the partial remainder, lo shifts dividend out / quotient in.
    assign div_shift = {hi_q, lo_q[31]};
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ge    = ~div_diff[32];
    assign div_hi_d  = div_ge ? div_diff[31:0] : div_shift[31:0];
    assign div_lo_d  = {lo_q[30:0], div_ge};

    always_comb begin
        div_result_d = 32'd0;
        if (func3_q[1]) begin
            div_result_d = neg_q ? (32'd0 - div_hi_d) : div_hi_d;
        end else begin
            div_result_d = neg_q ? (32'd0 - div_lo_d) : div_lo_d;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q  <= S_IDLE;
            cnt_q    <= 5'd0;
            func3_q  <= 2'd0;
            neg_q    <= 1'b0;
            opb_q    <= 32'd0;
            hi_q     <= 32'd0;
            lo_q     <= 32'd0;
            result_q <= 32'd0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else if (bus.FLUSH) begin
            state_q <= S_IDLE;
            cnt_q   <= 5'd0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    if (bus.START) begin
                        func3_q <= bus.FUNC3[1:0];
                        neg_q   <= start_neg_d;
                        opb_q   <= mag_b_d;
                        hi_q    <= 32'd0;
                        lo_q    <= mag_a_d;
                        cnt_q   <= 5'd0;
                        if (div_zero || div_ovf) begin
                            state_q  <= S_DONE;
                            done_q   <= 1'b1;
                            result_q <= special_result_d;
                        end else begin
                            state_q <= bus.FUNC3[2] ? S_DIV : S_MUL;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    hi_q  <= mul_hi_d;
                    lo_q  <= mul_lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= mul_result_d;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                S_DIV: begin
                    hi_q  <= div_hi_d;
                    lo_q  <= div_lo_d;
                    cnt_q <= cnt_q + 5'd1;
                    if (cnt_q == 5'd31) begin
                        result_q <= div_result_d;
                        state_q  <= S_DONE;
                        busy_q   <= 1'b0;
                        done_q   <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.BUSY   = busy_q;
    assign bus.DONE   = done_q;
    assign bus.RESULT = result_q;
    assign bus.STALL  = ~RESET & (busy_q | (bus.START & accept & ~bus.FLUSH));

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Bench for muldiv_sequencer: directed vectors plus randomized operations
// checked against plain-arithmetic RV32M results and latencies.
module tb_muldiv_sequencer;

    logic CLK;
    logic RESET;
    int   checks;
    int   errors;

    muldiv_sequencer_if bus ();

    muldiv_sequencer dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    function automatic bit is_special(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && b == 32'd0) return 1'b1;
        if ((f == 3'd4 || f == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [31:0] ref_result(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb;
        logic [63:0] ua, ub, p;
        int          ia, ib;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = {32'd0, a};
        ub = {32'd0, b};
        ia = $signed(a);
        ib = $signed(b);
        case (f)
            3'd0: begin p = ua * ub; return p[31:0]; end
            3'd1: begin p = 64'(sa * sb); return p[63:32]; end
            3'd2: begin p = 64'(sa * longint'(ub)); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 32'd0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 32'd0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
                return 32'(ia % ib);
            end
            default: return (b == 32'd0) ? a : a % b;
        endcase
    endfunction

    // Issue one operation from IDLE/DONE and follow it to its DONE cycle;
    // operands are scrambled while busy and START can be poked mid-flight.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input string tag, input bit poke);
        logic [31:0] exp_r;
        int          exp_lat;
        int          lat;
        int          busy_cnt;
        exp_r   = ref_result(f, a, b);
        exp_lat = is_special(f, a, b) ? 0 : 32;
        bus.START    = 1'b1;
        bus.FUNC3    = f;
        bus.OPERAND1 = a;
        bus.OPERAND2 = b;
        bus.FLUSH    = 1'b0;
        #1;
        chk({tag, " stall_on_start"}, 32'(bus.STALL), 32'd1);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        lat      = 0;
        busy_cnt = 0;
        while (bus.DONE !== 1'b1 && lat < 40) begin
            if (bus.BUSY === 1'b1 && bus.STALL === 1'b1) busy_cnt++;
            bus.OPERAND1 = $urandom;
            bus.OPERAND2 = $urandom;
            bus.FUNC3    = 3'($urandom);
            bus.START    = poke && (lat == 5);
            @(posedge CLK); #1;
            lat++;
        end
        bus.START = 1'b0;
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        chk({tag, " busy_cycles"}, 32'(busy_cnt), 32'(exp_lat));
        chk({tag, " result"}, bus.RESULT, exp_r);
    endtask

    task automatic done_drop(input string tag);
        logic [31:0] held;
        held = bus.RESULT;
        @(posedge CLK); #1;
        chk({tag, " done_one_cycle"}, 32'(bus.DONE), 32'd0);
        chk({tag, " idle_not_busy"}, 32'(bus.BUSY), 32'd0);
        chk({tag, " result_hold"}, bus.RESULT, held);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] held;
        logic [2:0]  rf;
        logic [31:0] ra, rb;
        int          dones;
        int          sel;
        checks = 0;
        errors = 0;

        RESET        = 1'b1;
        bus.START    = 1'b1;
        bus.FUNC3    = 3'd0;
        bus.OPERAND1 = 32'd0;
        bus.OPERAND2 = 32'd0;
        bus.FLUSH    = 1'b0;
        @(posedge CLK); #1;
        chk("reset busy", 32'(bus.BUSY), 32'd0);
        chk("reset done", 32'(bus.DONE), 32'd0);
        chk("reset result", bus.RESULT, 32'd0);
        chk("reset stall", 32'(bus.STALL), 32'd0);
        bus.START = 1'b0;
        RESET     = 1'b0;

        do_op(3'd0, 32'h0000_0007, 32'hFFFF_FFFD, "mul_7x-3", 1'b0);
        done_drop("mul_7x-3");
        do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhu_ff", 1'b0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulh_ff", 1'b0);
        do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "mulhsu_ff", 1'b0);
        done_drop("mulhsu_ff");
        do_op(3'd4, 32'hFFFF_FFF9, 32'h0000_0002, "div_-7/2", 1'b0);
        do_op(3'd6, 32'hFFFF_FFF9, 32'h0000_0002, "rem_-7/2", 1'b0);
        done_drop("rem_-7/2");
        do_op(3'd5, 32'd100, 32'd7, "divu_100/7", 1'b0);
        do_op(3'd7, 32'd100, 32'd7, "remu_b2b", 1'b0);
        done_drop("remu_b2b");
        do_op(3'd5, 32'd5, 32'd0, "divu_by0", 1'b0);
        do_op(3'd7, 32'd5, 32'd0, "remu_by0", 1'b0);
        do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, "div_ovf", 1'b0);
        done_drop("div_ovf");
        do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, "rem_ovf", 1'b0);
        do_op(3'd0, 32'h0001_2345, 32'h0000_0100, "mul_poke", 1'b1);
        done_drop("mul_poke");

        // Flush at iteration 10 of a multiply.
        held = bus.RESULT;
        bus.START    = 1'b1;
        bus.FUNC3    = 3'd0;
        bus.OPERAND1 = 32'd9;
        bus.OPERAND2 = 32'd9;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (10) begin @(posedge CLK); #1; end
        chk("flush pre busy", 32'(bus.BUSY), 32'd1);
        bus.FLUSH = 1'b1;
        @(posedge CLK); #1;
        bus.FLUSH = 1'b0;
        chk("flush busy_low", 32'(bus.BUSY), 32'd0);
        chk("flush stall_low", 32'(bus.STALL), 32'd0);
        dones = 0;
        repeat (40) begin
            if (bus.DONE === 1'b1) dones++;
            @(posedge CLK); #1;
        end
        chk("flush no_done", 32'(dones), 32'd0);
        chk("flush result_hold", bus.RESULT, held);

        // Flush beats a simultaneous START.
        bus.START = 1'b1;
        bus.FLUSH = 1'b1;
        #1;
        chk("flush_start stall", 32'(bus.STALL), 32'd0);
        @(posedge CLK); #1;
        bus.START = 1'b0;
        bus.FLUSH = 1'b0;
        chk("flush_start busy", 32'(bus.BUSY), 32'd0);
        chk("flush_start done", 32'(bus.DONE), 32'd0);

        // Reset between edges in the middle of a divide.
        do_op(3'd5, 32'd1000, 32'd3, "divu_pre_reset", 1'b0);
        bus.START    = 1'b1;
        bus.FUNC3    = 3'd4;
        bus.OPERAND1 = 32'h7654_3210;
        bus.OPERAND2 = 32'd13;
        @(posedge CLK); #1;
        bus.START = 1'b0;
        repeat (7) begin @(posedge CLK); #1; end
        #2;
        RESET     = 1'b1;
        bus.START = 1'b1;
        #1;
        chk("async_reset busy", 32'(bus.BUSY), 32'd0);
        chk("async_reset done", 32'(bus.DONE), 32'd0);
        chk("async_reset result", bus.RESULT, 32'd0);
        chk("async_reset stall", 32'(bus.STALL), 32'd0);
        @(posedge CLK); #1;
        RESET     = 1'b0;
        bus.START = 1'b0;
        do_op(3'd0, 32'd3, 32'd4, "mul_after_reset", 1'b0);
        done_drop("mul_after_reset");

        for (int i = 0; i < 30; i++) begin
            rf  = 3'($urandom);
            ra  = $urandom;
            rb  = $urandom;
            sel = int'($urandom_range(0, 7));
            if (sel == 0) rb = 32'd0;
            else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
            else if (sel == 2) begin ra = 32'($urandom_range(0, 200)); rb = 32'($urandom_range(1, 20)); end
            else if (sel == 3) rb = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
            do_op(rf, ra, rb, $sformatf("rnd%0d_f%0d", i, rf), ($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 1) == 1) done_drop($sformatf("rnd%0d", i));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have port CLK, input, 1, the single clock; all state changes on its rising edge.
REQ-002 SHALL have port RESET, input, 1, asynchronous active-high reset.
REQ-003 SHALL have port START, input, 1, requests an M-extension operation; sampled only in IDLE or DONE.
REQ-004 SHALL have port FUNC3, input, 3, operation select: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
REQ-005 SHALL have port OPERAND1, input, 32, rs1 value (multiplicand/dividend).
REQ-006 SHALL have port OPERAND2, input, 32, rs2 value (multiplier/divisor).
REQ-007 SHALL have port FLUSH, input, 1, synchronous abort of the operation in flight.
REQ-008 SHALL have port BUSY, output, 1, high while an operation iterates.
REQ-009 SHALL have port STALL, output, 1, combinational pipeline hold: BUSY OR (START AND state in IDLE/DONE AND NOT FLUSH).
REQ-010 SHALL have port DONE, output, 1, one-cycle result-valid strobe.
REQ-011 SHALL have port RESULT, output, 32, registered result.

Function
REQ-012 SHALL implement FSM states IDLE, MUL, DIV, DONE; BUSY = (state is MUL or DIV); DONE = (state is DONE).
REQ-013 SHALL, at an edge with START=1 in IDLE or DONE, latch FUNC3, OPERAND1 and OPERAND2, clear the iteration counter, and enter MUL (FUNC3[2]=0) or DIV (FUNC3[2]=1).
REQ-014 SHALL ignore START, FUNC3 and operand changes while BUSY.
REQ-015 SHALL perform exactly one iteration per edge in MUL/DIV using a 5-bit counter; the edge on which the counter reads 31 SHALL load RESULT and enter DONE, so DONE is high during the 32nd cycle after the START edge.
REQ-016 SHALL leave DONE after one cycle, going to IDLE, or to MUL/DIV if START=1 (back-to-back).
REQ-017 SHALL update RESULT only on entry to DONE; it holds otherwise.
REQ-018 MUL SHALL return product bits [31:0]; MULH, MULHSU and MULHU SHALL return bits [63:32] of the 64-bit product with signed x signed, signed x unsigned and unsigned x unsigned operands respectively.
REQ-019 DIV/DIVU SHALL return the quotient truncated toward zero; REM/REMU SHALL return the remainder with the dividend's sign (signed forms).
REQ-020 SHALL treat divide-by-zero as a special case: go from START directly to DONE (DONE in the next cycle); DIV/DIVU return 0xFFFFFFFF; REM/REMU return OPERAND1.
REQ-021 SHALL treat signed overflow (DIV/REM, 0x80000000 / 0xFFFFFFFF) as a special case with the same 1-cycle path: DIV returns 0x80000000 and REM returns 0x00000000.
REQ-022 SHALL, on FLUSH=1 at an edge, enter IDLE regardless of state; no DONE is produced and RESULT holds; FLUSH overrides a simultaneous START.

Reset
REQ-023 SHALL, while RESET=1 and without waiting for a clock edge, force state IDLE, counter 0, BUSY 0, DONE 0, RESULT 0x00000000 and all working registers 0; STALL=0 while RESET=1.
REQ-024 SHALL discard any operation in flight at reset and accept START on the first edge after RESET deasserts.

Verification
REQ-025 MUL 0x00000007 x 0xFFFFFFFD -> BUSY high for 32 cycles, DONE high exactly 32 cycles after the START edge, RESULT=0xFFFFFFEB.
REQ-026 0xFFFFFFFF x 0xFFFFFFFF -> MULHU 0xFFFFFFFE, MULH 0x00000000, MULHSU 0xFFFFFFFF.
REQ-027 DIV 0xFFFFFFF9 / 0x00000002 -> 0xFFFFFFFD; REM of the same -> 0xFFFFFFFF; DIVU 100 / 7 -> 14, then REMU back-to-back from DONE -> 2.
REQ-028 DIVU 5 / 0 -> DONE in the next cycle with RESULT 0xFFFFFFFF; REMU 5 / 0 -> 5; DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000 with 1-cycle latency.
REQ-029 FLUSH at iteration 10 -> BUSY low on the next cycle, no DONE pulse, RESULT unchanged; START pulsed mid-operation -> ignored, latency still 32.
REQ-030 RESET raised mid-DIV between clock edges -> BUSY, DONE and RESULT 0 immediately; after release, a new MUL 3 x 4 -> 12.
